nonce_frame_tx: RTL

- Host-bound result path: buffers 64-bit nonces found by the hash core and serializes each into a fixed 10-byte frame.
- Drives the byte-level UART transmitter through its start/busy handshake.
- Acts as the initiator on that handshake; the transmitter is the responder.
- Sits between hash-core result output and the UART TX pin logic.

---
 rtl/nonce_frame_tx_if.sv | 30 +++
 rtl/nonce_frame_tx.sv | 116 +++++++++++
 2 files changed

// File: rtl/nonce_frame_tx_if.sv
// nonce_frame_tx_if: bundles the nonce push handshake, the byte transmitter
// start/busy handshake and the status outputs of nonce_frame_tx.
//   master : the framer (accepts nonces, initiates tx_start, reports status)
//   slave  : the environment (hash core + UART transmitter + host status)
interface nonce_frame_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          nonce_valid;
  logic [63:0]   nonce_data;
  logic          nonce_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          frame_done;
  logic          overflow;

  modport master (
    input  nonce_valid, nonce_data, tx_busy,
    output nonce_ready, tx_start, tx_data, fifo_count, busy, frame_done, overflow
  );

  modport slave (
    output nonce_valid, nonce_data, tx_busy,
    input  nonce_ready, tx_start, tx_data, fifo_count, busy, frame_done, overflow
  );
endinterface

// File: rtl/nonce_frame_tx.sv
// nonce_frame_tx: buffers 64-bit nonces in a small circular FIFO and sends
// each one as a 10-byte frame {SYNC, nonce bytes LSB first, XOR checksum}
// through a byte transmitter using a one-cycle tx_start / tx_busy handshake.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   bus (master) : nonce_valid/nonce_data/nonce_ready push side,
//                  tx_start/tx_data/tx_busy transmitter side,
//                  fifo_count, busy, frame_done, overflow status
module nonce_frame_tx #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input logic              clk,
  input logic              rst,
  nonce_frame_tx_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [63:0]   frame;
  logic [7:0]    chk;
  logic [3:0]    byte_idx;
  logic [63:0]   head;
  logic [7:0]    head_chk, cur_byte;
  logic [2:0]    nonce_sel;
  logic          push, pop;

  // Full blocks pushes even when a pop happens the same cycle.
  assign bus.nonce_ready = (count != FULL);
  assign push            = bus.nonce_valid & bus.nonce_ready;
  assign pop             = (state == S_IDLE) && (count != '0);
  assign head            = mem[rd_ptr];
  assign bus.fifo_count  = count;
  assign bus.busy        = (state != S_IDLE);

  always_comb begin
    head_chk = '0;
    for (int i = 0; i < 8; i++) head_chk ^= head[8*i +: 8];
  end

  // Byte 0 is the preamble, 1..8 the nonce bytes LSB first, 9 the checksum.
  assign nonce_sel = 3'(byte_idx - 4'd1);
  always_comb begin
    cur_byte = SYNC_BYTE;
    if (byte_idx == 4'd9)       cur_byte = chk;
    else if (byte_idx != 4'd0)  cur_byte = frame[{nonce_sel, 3'b000} +: 8];
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.nonce_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.overflow   <= 1'b0;
      state          <= S_IDLE;
      frame          <= '0;
      chk            <= '0;
      byte_idx       <= '0;
      bus.tx_start   <= 1'b0;
      bus.tx_data    <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.nonce_valid && !bus.nonce_ready) bus.overflow <= 1'b1;

      bus.tx_start   <= 1'b0;
      bus.frame_done <= 1'b0;
      case (state)
        S_IDLE: if (pop) begin
          frame    <= head;
          chk      <= head_chk;
          byte_idx <= '0;
          state    <= S_SEND;
        end
        S_SEND: if (!bus.tx_busy) begin
          bus.tx_start <= 1'b1;
          bus.tx_data  <= cur_byte;
          state        <= S_ACK;
        end
        // Wait for the transmitter to take the byte, then for it to finish.
        S_ACK: if (bus.tx_busy) state <= S_DONE;
        S_DONE: if (!bus.tx_busy) begin
          if (byte_idx == 4'd9) begin
            bus.frame_done <= 1'b1;
            state          <= S_IDLE;
          end else begin
            byte_idx <= byte_idx + 4'd1;
            state    <= S_SEND;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
